// File: rtl/sub_pipe_sat.sv
// sub_pipe_sat: pipelined subtractor with borrow-in/borrow-out, valid/ready
// flow control and a per-operation wrap / unsigned-saturate / signed-saturate
// mode. The borrow chain is cut into CHUNK-bit slices, and one slice is
// resolved per stage. Stage 0 resolves its slice directly from the input
// operands. Every stage then registers its result, so the last register set is
// the output register. The latency is therefore NSTAGE = ceil(WIDTH/CHUNK)
// cycles, and the block accepts one new operation per cycle.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset; drops every in-flight result
//   in_valid   operand set present
//   in_ready   block accepts operands this cycle (combinational)
//   a, b, bi   minuend, subtrahend, borrow-in: raw = a - b - bi
//   mode       00 wrap, 01 unsigned saturate, 10 signed saturate, 11 wrap
//   out_valid  result present
//   out_ready  downstream accepts the result
//   diff       result after mode handling
//   bo         raw borrow-out of the unsigned subtraction
//   ovf        signed overflow of the raw subtraction
//   sat        diff was clamped for this result
module sub_pipe_sat #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             ovf,
  output logic             sat
);

  localparam int NSTAGE = (WIDTH + CHUNK - 1) / CHUNK;
  // Inter-stage register sets; a single-stage pipe needs none, but the array
  // keeps one dummy entry so that it never has zero size.
  localparam int NREG   = (NSTAGE > 1) ? NSTAGE - 1 : 1;
  localparam int MSB    = WIDTH - 1;

  typedef enum logic [1:0] {
    MODE_WRAP  = 2'b00,
    MODE_USAT  = 2'b01,
    MODE_SSAT  = 2'b10,
    MODE_WRAP3 = 2'b11
  } mode_e;

  // Registers between stage k and stage k+1.
  logic [WIDTH-1:0] pa  [NREG];
  logic [WIDTH-1:0] pb  [NREG];
  logic [WIDTH-1:0] pd  [NREG];
  logic             pbr [NREG];
  logic [1:0]       pm  [NREG];
  logic             pv  [NREG];

  // Inputs seen by stage k: the ports for stage 0, and the registers otherwise.
  logic [WIDTH-1:0] sa  [NSTAGE];
  logic [WIDTH-1:0] sb  [NSTAGE];
  logic [WIDTH-1:0] sd  [NSTAGE];
  logic             sbr [NSTAGE];
  logic [1:0]       sm  [NSTAGE];
  logic             sv  [NSTAGE];

  // Stage k outputs: difference bits resolved so far, and the outgoing borrow.
  logic [WIDTH-1:0] nd  [NSTAGE];
  logic             nbr [NSTAGE];

  logic             adv;
  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             b_msb;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_diff;
  logic             fin_sat;

  // The whole pipe moves as one shift register. It stalls only when a result
  // is waiting that the consumer has not taken.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_comb begin
    sa[0]  = a;
    sb[0]  = b;
    sd[0]  = '0;
    sbr[0] = bi;
    sm[0]  = mode;
    sv[0]  = in_valid;
    for (int k = 1; k < NSTAGE; k++) begin
      sa[k]  = pa[k-1];
      sb[k]  = pb[k-1];
      sd[k]  = pd[k-1];
      sbr[k] = pbr[k-1];
      sm[k]  = pm[k-1];
      sv[k]  = pv[k-1];
    end

    // Ripple the borrow through this stage's slice only. Bits above WIDTH
    // never enter the loop, so the last slice is truncated automatically.
    // NOTE: blocking assignments here so that nbr[k] carries bit to bit within
    // one evaluation; every output gets a default first so no latch is
    // inferred.
    for (int k = 0; k < NSTAGE; k++) begin
      nd[k]  = sd[k];
      nbr[k] = sbr[k];
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= k * CHUNK && i < (k + 1) * CHUNK) begin
          nd[k][i] = sa[k][i] ^ sb[k][i] ^ nbr[k];
          nbr[k]   = (~sa[k][i] & sb[k][i]) | (~(sa[k][i] ^ sb[k][i]) & nbr[k]);
        end
      end
    end
  end

  // Mode handling on the fully resolved difference, in the last stage.
  always_comb begin
    raw      = nd[NSTAGE-1];
    a_msb    = sa[NSTAGE-1][MSB];
    b_msb    = sb[NSTAGE-1][MSB];
    // A signed overflow is possible only when the operand signs differ, and it
    // shows up as a result whose sign disagrees with the minuend.
    fin_ovf  = (a_msb != b_msb) && (raw[MSB] != a_msb);
    fin_diff = raw;
    fin_sat  = 1'b0;
    case (mode_e'(sm[NSTAGE-1]))
      MODE_USAT: begin
        if (nbr[NSTAGE-1]) begin
          fin_diff = '0;
          fin_sat  = 1'b1;
        end
      end
      MODE_SSAT: begin
        if (fin_ovf) begin
          // Non-negative minuend overflowed upward: clamp to max positive.
          fin_diff = a_msb ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
          fin_sat  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control state: valid bits and the visible outputs are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bo        <= 1'b0;
      ovf       <= 1'b0;
      sat       <= 1'b0;
      for (int k = 0; k < NREG; k++) pv[k] <= 1'b0;
    end else if (adv) begin
      out_valid <= sv[NSTAGE-1];
      // Load only on a real result, so that the outputs keep their last value
      // while bubbles pass through.
      if (sv[NSTAGE-1]) begin
        diff <= fin_diff;
        bo   <= nbr[NSTAGE-1];
        ovf  <= fin_ovf;
        sat  <= fin_sat;
      end
      for (int k = 0; k < NSTAGE - 1; k++) pv[k] <= sv[k];
    end
  end

  // NOTE: the internal datapath registers have no reset. They are only
  // observed behind a set valid bit, so reset would add fan-out and buy
  // nothing.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < NSTAGE - 1; k++) begin
        pa[k]  <= sa[k];
        pb[k]  <= sb[k];
        pd[k]  <= nd[k];
        pbr[k] <= nbr[k];
        pm[k]  <= sm[k];
      end
    end
  end

endmodule

// File: tb/tb_sub_pipe_sat.sv
// Scoreboard bench for sub_pipe_sat. Two instances are used:
//   unit 0: WIDTH=16, CHUNK=8 (2 stages)
//   unit 1: WIDTH=13, CHUNK=4 (4 stages, last stage 1 bit wide)
// For each accepted operation, the expected result is computed by plain
// integer arithmetic and pushed into a queue. A negedge monitor pops the queue
// on every output transfer. The monitor also checks the in_ready rule and that
// the outputs stay stable under backpressure.
module tb_sub_pipe_sat;

  typedef struct packed {
    logic [15:0] diff;
    logic        bo;
    logic        ovf;
    logic        sat;
    logic        chk_lat;
    logic [31:0] acc;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nst[2] = '{2, 4};
  int wid[2] = '{16, 13};

  logic        clk = 1'b0;
  logic [1:0]  rst_v;
  logic [1:0]  iv;
  logic [1:0]  ordy;
  logic [1:0]  bi_v;
  logic [15:0] a_s [2];
  logic [15:0] b_s [2];
  logic [1:0]  mode_s [2];
  wire  [1:0]  ir;
  wire  [1:0]  ov;
  wire  [1:0]  bo_v;
  wire  [1:0]  ovf_v;
  wire  [1:0]  sat_v;
  wire  [15:0] diff0;
  wire  [12:0] diff13;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [1:0]  held = '0;
  logic [18:0] hd [2];
  bit          done;

  sub_pipe_sat #(.WIDTH(16), .CHUNK(8)) dut (
    .clk(clk), .rst(rst_v[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s[0]), .b(b_s[0]), .bi(bi_v[0]), .mode(mode_s[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .diff(diff0),
    .bo(bo_v[0]), .ovf(ovf_v[0]), .sat(sat_v[0])
  );

  sub_pipe_sat #(.WIDTH(13), .CHUNK(4)) dut13 (
    .clk(clk), .rst(rst_v[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s[1][12:0]), .b(b_s[1][12:0]), .bi(bi_v[1]), .mode(mode_s[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .diff(diff13),
    .bo(bo_v[1]), .ovf(ovf_v[1]), .sat(sat_v[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected behaviour from integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bi, input logic [1:0] mode);
    exp_t   e;
    longint m  = longint'(1) << w;
    longint h  = m / 2;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= h) ? ua - m : ua;
    longint sb = (ub >= h) ? ub - m : ub;
    longint ud = ua - ub - longint'(bi);
    longint sd = sa - sb - longint'(bi);
    e      = '0;
    e.bo   = (ud < 0);
    e.ovf  = (sd < -h) || (sd > h - 1);
    e.diff = 16'((ud < 0) ? ud + m : ud);
    if (mode == 2'b01 && e.bo) begin
      e.diff = '0;
      e.sat  = 1'b1;
    end else if (mode == 2'b10 && e.ovf) begin
      e.diff = (sd > 0) ? 16'(h - 1) : 16'(h);
      e.sat  = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [15:0] dget(input int u);
    return (u == 0) ? diff0 : {3'b000, diff13};
  endfunction

  function automatic logic [18:0] act(input int u);
    return {dget(u), bo_v[u], ovf_v[u], sat_v[u]};
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mon(input int u);
    exp_t e;
    if (rst_v[u]) begin
      held[u] = 1'b0;
      return;
    end
    if (held[u])
      check(ov[u] && act(u) == hd[u], "hold_stable", {12'b0, ov[u], act(u)}, {13'h1, hd[u]});
    check(ir[u] == (ordy[u] | ~ov[u]), "in_ready", 32'(ir[u]), 32'(ordy[u] | ~ov[u]));
    if (ov[u] && ordy[u]) begin
      if (qsize(u) == 0) begin
        check(1'b0, "unexpected_out", 32'(act(u)), 32'h0);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        check(act(u) == {e.diff, e.bo, e.ovf, e.sat}, "result",
              32'(act(u)), 32'({e.diff, e.bo, e.ovf, e.sat}));
        if (e.chk_lat)
          check(cyc - int'(e.acc) == nst[u], "latency", 32'(cyc - int'(e.acc)), 32'(nst[u]));
      end
    end
    held[u] = ov[u] & ~ordy[u];
    hd[u]   = act(u);
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) mon(u);
  end

  // Offer one operation and wait (bounded) for acceptance. Returns one cycle
  // after the accepting edge with in_valid dropped.
  task automatic op(input int u, input logic [15:0] a, input logic [15:0] b,
                    input logic bi, input logic [1:0] mode, input bit lat);
    exp_t e;
    bit   taken;
    e         = model(wid[u], a, b, bi, mode);
    e.chk_lat = lat;
    iv[u]     = 1'b1;
    a_s[u]    = a;
    b_s[u]    = b;
    bi_v[u]   = bi;
    mode_s[u] = mode;
    taken     = 1'b0;
    for (int t = 0; t < 200 && !taken; t++) begin
      @(negedge clk);
      if (ir[u]) begin
        e.acc = 32'(cyc);
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
        taken = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!taken) check(1'b0, "accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    iv[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    for (int t = 0; t < 100 && qsize(u) != 0; t++) @(posedge clk);
    #1;
    check(qsize(u) == 0, "drain", 32'(qsize(u)), 32'h0);
  endtask

  task automatic rand_phase(input int u, input int n);
    logic [15:0] mask;
    mask = 16'((32'h1 << wid[u]) - 1);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          op(u, 16'($urandom) & mask, 16'($urandom) & mask,
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ordy[u] = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    ordy[u] = 1'b1;
    drain(u);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 2'b11;
    iv    = 2'b00;
    ordy  = 2'b11;
    bi_v  = 2'b00;
    for (int u = 0; u < 2; u++) begin
      a_s[u]    = '0;
      b_s[u]    = '0;
      mode_s[u] = '0;
    end

    // Reset: in_ready must be high while the pipe is empty, even in reset.
    @(posedge clk);
    @(negedge clk);
    check(ir == 2'b11, "in_ready_in_reset", 32'(ir), 32'h3);
    @(posedge clk); #1;
    rst_v = 2'b00;
    @(negedge clk);
    for (int u = 0; u < 2; u++)
      check(!ov[u] && act(u) == '0, "reset_state", {12'b0, ov[u], act(u)}, 32'h0);
    @(posedge clk); #1;

    // Directed cases on the 16/8 instance, with the consumer always ready.
    op(0, 16'h0005, 16'h0007, 1'b0, 2'b00, 1'b1);
    op(0, 16'h0005, 16'h0007, 1'b0, 2'b01, 1'b1);
    op(0, 16'h1234, 16'h0234, 1'b1, 2'b01, 1'b1);
    op(0, 16'h8000, 16'h0001, 1'b0, 2'b10, 1'b1);
    op(0, 16'h7FFF, 16'hFFFF, 1'b0, 2'b10, 1'b1);
    op(0, 16'h0003, 16'h0005, 1'b1, 2'b11, 1'b1);
    op(0, 16'h00FF, 16'h00FF, 1'b1, 2'b00, 1'b1);
    drain(0);

    // Streaming: 8 back-to-back operations, with the consumer stalled for
    // cycles 3 to 5.
    fork
      begin
        for (int i = 0; i < 8; i++)
          op(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'b0);
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        ordy[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ordy[0] = 1'b1;
      end
    join
    drain(0);

    // Reset with two operations in flight: neither may ever appear.
    op(0, 16'h1111, 16'h2222, 1'b0, 2'b00, 1'b0);
    op(0, 16'h3333, 16'h0001, 1'b0, 2'b00, 1'b0);
    rst_v[0] = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    @(negedge clk);
    check(!ov[0] && diff0 == '0, "reset_flush", {15'b0, ov[0], diff0}, 32'h0);
    @(posedge clk); #1;
    op(0, 16'h0010, 16'h0001, 1'b0, 2'b00, 1'b1);
    repeat (6) begin @(posedge clk); #1; end
    drain(0);

    // 13/4 instance: the borrow must run through every slice boundary.
    op(1, 16'h0000, 16'h0000, 1'b1, 2'b00, 1'b1);
    op(1, 16'h1000, 16'h0FFF, 1'b0, 2'b10, 1'b1);
    op(1, 16'h0FFF, 16'h1FFF, 1'b0, 2'b10, 1'b1);
    op(1, 16'h0001, 16'h0002, 1'b0, 2'b01, 1'b1);
    drain(1);

    // Randomized traffic with random backpressure on both instances.
    rand_phase(1, 150);
    rand_phase(0, 250);

    check(q0.size() == 0 && q1.size() == 0, "final_empty",
          32'(q0.size() + q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_pipe_sat.md
Name: sub_pipe_sat

Overview:
- Parametrised, pipelined subtractor with borrow-in/borrow-out.
- Successor to the fixed 8-bit combinational ripple-borrow subtractor macro: width is generalised, and the borrow chain is split into registered chunks.
- Adds valid/ready flow control and a per-operation wrap / unsigned-saturate / signed-saturate mode.
- Sits in the datapath between operand registers and downstream consumers that may apply backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits; legal values WIDTH >= 2.
- CHUNK, 8, bits resolved per pipeline stage; legal values 1 <= CHUNK <= WIDTH.
- NSTAGE (localparam), ceil(WIDTH/CHUNK), number of pipeline stages and latency in cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bi  in  1  borrow-in; result = a - b - bi.
- mode  in  2  00 wrap, 01 unsigned saturate, 10 signed saturate, 11 treated as wrap.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- diff  out  WIDTH  result after mode handling.
- bo  out  1  raw borrow-out of the unsigned subtraction, before saturation.
- ovf  out  1  signed overflow flag, before saturation.
- sat  out  1  diff was clamped this result.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on rst=1 at a clock edge, all stage valid bits clear; out_valid=0, diff=0, bo=0, ovf=0, sat=0.
  - in_ready is combinational and evaluates to 1 while the pipe is empty, including during reset.
  - Operands offered while rst=1 are discarded. Reset mid-operation drops all in-flight results without emitting them.
- Advance rule: adv = out_ready | ~out_valid.
  - All stages shift together when adv=1 and hold when adv=0.
  - in_ready = adv, combinational, with no dependency on in_valid.
- Accept: a transfer occurs when in_valid & in_ready. Stage 0 captures a, b, bi and mode.
  - If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Datapath:
  - Stage k resolves bits [k*CHUNK +: CHUNK], with the last chunk truncated to WIDTH.
  - The stage uses the borrow registered from stage k-1; stage 0 uses bi.
  - Each stage forwards unresolved operand bits, resolved difference bits, borrow, mode and valid.
  - Per bit: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
- Latency: exactly NSTAGE cycles from accept to out_valid when not stalled. Throughput is 1 result per cycle.
- Final stage, applied in the same cycle as the last chunk and registered into the outputs:
  - bo = final borrow.
  - ovf = (a[MSB] != b[MSB]) & (raw[MSB] != a[MSB]).
  - mode 01 with bo=1: diff = 0, sat = 1.
  - mode 10 with ovf=1: diff = 0x7F..F if a[MSB]=0, else 0x80..0; sat = 1.
  - Otherwise diff = raw mod 2^WIDTH, sat = 0.
- Backpressure: while out_valid=1 and out_ready=0, diff, bo, ovf and sat hold stable, and no stage changes.
- Simultaneous out_ready=1 with in_valid=1 on a full pipe: the output retires and the new input enters in the same cycle. Nothing is lost or duplicated.
- mode is evaluated per operation as captured; changes on the input never affect in-flight results.
- Boundary, WIDTH = CHUNK: NSTAGE = 1, latency 1.
- Boundary, WIDTH not a multiple of CHUNK: the last stage handles WIDTH mod CHUNK bits.

Test Plan:
- WIDTH=16, CHUNK=8, mode=00: a=0x0005, b=0x0007, bi=0 -> 2 cycles later diff=0xFFFE, bo=1, ovf=0, sat=0.
- Same config, mode=01: a=0x0005, b=0x0007 -> diff=0x0000, bo=1, sat=1. Then a=0x1234, b=0x0234, bi=1 -> diff=0x0FFF, bo=0, sat=0.
- mode=10: a=0x8000, b=0x0001 -> diff=0x8000, ovf=1, sat=1. Then a=0x7FFF, b=0xFFFF -> diff=0x7FFF, ovf=1, sat=1.
- Streaming: 8 back-to-back ops with out_ready low for cycles 3-5 -> in_ready low exactly while out_valid & ~out_ready; all 8 results appear in order with correct values and no duplicates.
- Reset mid-stream: assert rst with 2 ops in flight -> next cycle out_valid=0 and diff=0; the in-flight ops never emerge; a new op after reset completes in 2 cycles.
- WIDTH=13, CHUNK=4 (NSTAGE=4): a=0x0000, b=0x0000, bi=1, mode=00 -> 4 cycles later diff=0x1FFF, bo=1. Borrow propagates through all chunk boundaries.
